// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the unified memory arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10} state_t;
   typedef enum logic [1:0] {NONE = 2'b00, OWN_I = 2'b01, OWN_D = 2'b10} owner_t;
   localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select between fetch and data requests
module arb_pick
   import mem_arb_pkg::*;
#(
   parameter int PRIORITY = 0
) (
   input  logic   i_req,
   input  logic   d_req,
   input  owner_t last_owner,
   output owner_t win
);
   // fixed priority may starve the fetch port; round-robin hands the tie to whoever did not go last
   always_comb
      win = (i_req && d_req) ? ((PRIORITY != 0 || last_owner == OWN_I) ? OWN_D : OWN_I)
          : d_req ? OWN_D : i_req ? OWN_I : NONE;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between the fetch and load/store ports,
// with req/ack handshake, one-cycle done pulses and a timeout abort
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int PRIORITY = 0,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ack,
   output logic              bus_err,
   output logic [1:0]        owner
);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   state_t         state;
   owner_t         own, last_owner, win;
   logic [CW-1:0]  cnt;
   logic           tmo;
   assign tmo   = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
   assign owner = own;
   arb_pick #(.PRIORITY(PRIORITY)) u_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_owner (last_owner),
      .win        (win)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= IDLE;
         own        <= NONE;
         last_owner <= OWN_D;
         cnt        <= '0;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         bus_err <= 1'b0;
         case (state)
            IDLE:
               if (win != NONE) begin
                  own     <= win;
                  m_req   <= 1'b1;
                  m_we    <= win == OWN_D && d_we;
                  m_addr  <= win == OWN_D ? d_addr : i_addr;
                  m_wdata <= win == OWN_D ? d_wdata : '0;
                  cnt     <= '0;
                  state   <= ACCESS;
               end
            ACCESS:
               if (m_ack || tmo) begin
                  // an aborted read returns zero so the core never consumes stale data
                  if (own == OWN_I) i_rdata <= m_ack ? m_rdata : '0;
                  else if (!m_we) d_rdata <= m_ack ? m_rdata : '0;
                  if (m_ack) last_owner <= own;
                  bus_err <= !m_ack;
                  i_done  <= own == OWN_I;
                  d_done  <= own == OWN_D;
                  m_req   <= 1'b0;
                  state   <= DONE;
               end else cnt <= cnt + 1'b1;
            DONE: begin
               own   <= NONE;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vector bench for the unified memory arbiter
module tb_unified_mem_arbiter;
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;

   logic        i_req = 0, d_req = 0, d_we = 0, m_ack = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic        i_done, d_done, m_req, m_we, bus_err;
   logic [1:0]  owner;

   unified_mem_arbiter #(.PRIORITY(0), .TIMEOUT(4)) u0 (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
      .bus_err(bus_err), .owner(owner)
   );

   logic        p_i_req = 0, p_d_req = 0;
   logic [31:0] p_i_rdata, p_d_rdata, p_m_addr, p_m_wdata;
   logic        p_i_done, p_d_done, p_m_req, p_m_we, p_bus_err;
   logic [1:0]  p_owner;

   unified_mem_arbiter #(.PRIORITY(1)) u1 (
      .clk(clk), .rst(rst), .i_req(p_i_req), .i_addr(32'h0000_0100), .i_rdata(p_i_rdata), .i_done(p_i_done),
      .d_req(p_d_req), .d_we(1'b0), .d_addr(32'h0000_0200), .d_wdata(32'h0), .d_rdata(p_d_rdata), .d_done(p_d_done),
      .m_req(p_m_req), .m_we(p_m_we), .m_addr(p_m_addr), .m_wdata(p_m_wdata), .m_rdata(32'h0), .m_ack(p_m_req),
      .bus_err(p_bus_err), .owner(p_owner)
   );

   int ncmp = 0, nerr = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", n, act, exp);
      end
   endtask

   typedef struct {
      logic        is_d, we;
      logic [31:0] addr, wdata, mem;
      int          ack_at, lat, mcyc;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t v[7];
   vec_t vr;

   // cycle 1 is the IDLE cycle in which the request is raised
   task automatic txn(input vec_t t, input string n);
      int          cyc = 1, mc = 0, lat = 0;
      logic        err = 0, stable = 1, we_s = 0, other = 0;
      logic [31:0] a_s = 0, w_s = 0;
      logic [1:0]  own_s = 0;
      if (t.is_d) begin
         d_req = 1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
      end else begin
         i_req = 1; i_addr = t.addr;
      end
      while (lat == 0 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
         m_ack = 0;
         if (m_req) begin
            mc++;
            if (mc == 1) begin
               a_s = m_addr; w_s = m_wdata; we_s = m_we;
               d_addr = ~t.addr; d_wdata = ~t.wdata; i_addr = ~t.addr; d_we = ~t.we;
            end else if (m_addr !== a_s || m_wdata !== w_s || m_we !== we_s) stable = 0;
            if (mc == t.ack_at) begin
               m_ack = 1; m_rdata = t.mem;
            end
         end
         if (i_done || d_done) begin
            lat = cyc; err = bus_err; own_s = owner;
            other = t.is_d ? i_done : d_done;
         end
      end
      i_req = 0; d_req = 0; m_ack = 0;
      chk({n, " latency"}, 32'(lat), 32'(t.lat));
      chk({n, " m_req cycles"}, 32'(mc), 32'(t.mcyc));
      chk({n, " bus_err"}, 32'(err), 32'(t.err));
      chk({n, " owner at done"}, 32'(own_s), t.is_d ? 32'd2 : 32'd1);
      chk({n, " other done"}, 32'(other), 32'd0);
      chk({n, " m_addr"}, a_s, t.addr);
      chk({n, " m_we"}, 32'(we_s), 32'(t.is_d && t.we));
      chk({n, " bus stable"}, 32'(stable), 32'd1);
      if (t.is_d) chk({n, " m_wdata"}, w_s, t.wdata);
      @(posedge clk); #1;
      chk({n, " owner after"}, 32'(owner), 32'd0);
      chk({n, " done after"}, 32'(i_done | d_done), 32'd0);
      chk({n, " rdata"}, t.is_d ? d_rdata : i_rdata, t.rdata);
   endtask

   initial begin
      logic [1:0] g[4];
      logic [1:0] rr_exp[4];
      logic       ri, rd;
      int         ng, ni, got;
      v[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0,         32'h0050_0093, 1, 3, 1, 1'b0, 32'h0050_0093};
      v[1] = '{1'b1, 1'b0, 32'h1001_0004, 32'h0,         32'h1234_5678, 2, 4, 2, 1'b0, 32'h1234_5678};
      v[2] = '{1'b1, 1'b1, 32'h1001_0000, 32'hCAFE_F00D, 32'hDEAD_BEEF, 4, 6, 4, 1'b0, 32'h1234_5678};
      v[3] = '{1'b1, 1'b0, 32'h1001_0008, 32'h0,         32'h5555_5555, 0, 6, 4, 1'b1, 32'h0};
      v[4] = '{1'b0, 1'b0, 32'h0040_0004, 32'h0,         32'h6666_6666, 0, 6, 4, 1'b1, 32'h0};
      v[5] = '{1'b0, 1'b0, 32'h0040_0010, 32'h0,         32'hA5A5_A5A5, 3, 5, 3, 1'b0, 32'hA5A5_A5A5};
      v[6] = '{1'b1, 1'b0, 32'h1001_0010, 32'h0,         32'h0BAD_CAFE, 4, 6, 4, 1'b0, 32'h0BAD_CAFE};
      vr   = '{1'b0, 1'b0, 32'h0040_0008, 32'h0,         32'h00A0_0113, 1, 3, 1, 1'b0, 32'h00A0_0113};
      rr_exp = '{2'd1, 2'd2, 2'd1, 2'd2};

      repeat (2) @(posedge clk);
      #1;
      chk("reset m_req", 32'(m_req), 32'd0);
      chk("reset m_we", 32'(m_we), 32'd0);
      chk("reset m_addr", m_addr, 32'h0);
      chk("reset m_wdata", m_wdata, 32'h0);
      chk("reset i_rdata", i_rdata, 32'h0);
      chk("reset d_rdata", d_rdata, 32'h0);
      chk("reset dones", 32'({i_done, d_done, bus_err}), 32'd0);
      chk("reset owner", 32'(owner), 32'd0);
      chk("reset p_owner", 32'(p_owner), 32'd0);
      rst = 1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) txn(v[i], $sformatf("v%0d", i));

      m_ack = 1; m_rdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      chk("idle ack owner", 32'(owner), 32'd0);
      chk("idle ack m_req", 32'(m_req), 32'd0);
      chk("idle ack done", 32'(i_done | d_done), 32'd0);
      chk("idle ack i_rdata", i_rdata, 32'hA5A5_A5A5);
      m_ack = 0;

      rst = 0;
      @(posedge clk); #1;
      rst = 1;
      i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h1000; d_addr = 32'h2000;
      ng = 0; ri = 0; rd = 0;
      g = '{2'd0, 2'd0, 2'd0, 2'd0};
      for (int c = 0; c < 60 && ng < 4; c++) begin
         @(posedge clk); #1;
         if (ri) begin i_req = 1; ri = 0; end
         if (rd) begin d_req = 1; rd = 0; end
         m_ack = m_req; m_rdata = 32'h7777_0000 + 32'(c);
         if (i_done || d_done) begin
            g[ng] = owner; ng++;
            if (i_done) begin i_req = 0; ri = 1; end
            if (d_done) begin d_req = 0; rd = 1; end
         end
      end
      i_req = 0; d_req = 0; m_ack = 0;
      for (int k = 0; k < 4; k++) chk($sformatf("rr grant %0d", k), 32'(g[k]), 32'(rr_exp[k]));
      repeat (2) @(posedge clk);
      #1;

      i_req = 1; i_addr = vr.addr;
      @(posedge clk); #1;
      chk("midrst m_req before", 32'(m_req), 32'd1);
      #3 rst = 0;
      #1;
      chk("midrst m_req async", 32'(m_req), 32'd0);
      chk("midrst owner", 32'(owner), 32'd0);
      @(posedge clk); #1;
      chk("midrst no done", 32'(i_done | d_done | bus_err), 32'd0);
      rst = 1;
      txn(vr, "post-reset fetch");

      p_i_req = 1; p_d_req = 1;
      ng = 0; ni = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         @(posedge clk); #1;
         if (p_i_done) ni++;
         if (p_d_done) begin
            ng++;
            if (ng == 4) p_d_req = 0;
         end
      end
      chk("prio d grants", 32'(ng), 32'd4);
      chk("prio i starved", 32'(ni), 32'd0);
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         @(posedge clk); #1;
         if (p_i_done) got = c + 1;
         if (p_d_done) ni = 99;
      end
      p_i_req = 0;
      chk("prio i after d drops", 32'(got), 32'd3);
      chk("prio no extra d", 32'(ni), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end
endmodule
